// File: rtl/frame_assembler.sv
// Collects a raster-ordered RGB pixel stream into a parallel LENGTH x WIDTH x 3 byte frame
// and pulses init_out once the final pixel has been stored.
module frame_assembler #(
    parameter int LENGTH      = 32,
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
    output logic [7:0]  image [LENGTH][WIDTH][3],
    output logic        init_out,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count,
    output logic        resync
);

    localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [RW-1:0] LAST_ROW  = RW'(LENGTH - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [HW-1:0] hold_cnt;

    logic          accept;
    logic          write_en;
    logic          at_last;
    logic          finish;
    logic [RW-1:0] wr_row;
    logic [RW-1:0] nxt_row;
    logic [CW-1:0] wr_col;
    logic [CW-1:0] nxt_col;

    // An SOF beat always lands at (0,0), whatever position the counters held.
    always_comb begin
        accept  = pix_valid && pix_ready;
        wr_row  = pix_sof ? '0 : row;
        wr_col  = pix_sof ? '0 : col;
        at_last = (wr_row == LAST_ROW) && (wr_col == LAST_COL);
        nxt_row = wr_row;
        nxt_col = wr_col + 1'b1;
        if (wr_col == LAST_COL) begin
            nxt_col = '0;
            nxt_row = wr_row + 1'b1;
        end
        write_en = accept && ((state == FILL) || (state == IDLE && pix_sof));
        finish   = accept && at_last &&
                   (((state == FILL) && !pix_sof) || ((state == IDLE) && pix_sof));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read in this
    // block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            hold_cnt    <= '0;
            pix_ready   <= 1'b1;
            busy        <= 1'b0;
            init_out    <= 1'b0;
            resync      <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
            // NOTE: the frame is a flop array, not a RAM macro, so clearing it on reset is legal
            // and gives the classifier a defined all-zero image before the first frame.
            for (int r = 0; r < LENGTH; r++)
                for (int c = 0; c < WIDTH; c++)
                    for (int ch = 0; ch < 3; ch++)
                        image[r][c][ch] <= '0;
        end else begin
            init_out <= 1'b0;
            resync   <= 1'b0;

            if (write_en)
                for (int ch = 0; ch < 3; ch++)
                    image[wr_row][wr_col][ch] <= pix_data[8*ch +: 8];

            if (finish) begin
                state       <= HOLD;
                init_out    <= 1'b1;
                frame_count <= frame_count + 1'b1;
                hold_cnt    <= '0;
                pix_ready   <= 1'b0;
                busy        <= 1'b1;
                row         <= '0;
                col         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && pix_sof) begin
                            state <= FILL;
                            busy  <= 1'b1;
                            row   <= nxt_row;
                            col   <= nxt_col;
                        end else if (accept && drop_count != 8'hFF) begin
                            drop_count <= drop_count + 1'b1;
                        end
                    end
                    FILL: begin
                        if (accept) begin
                            resync <= pix_sof;
                            row    <= nxt_row;
                            col    <= nxt_col;
                        end
                    end
                    HOLD: begin
                        // Consumer settle window: no beats are accepted, so SOF cannot land here.
                        if (hold_cnt == LAST_HOLD) begin
                            state     <= IDLE;
                            pix_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        pix_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
